// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
// ---------------------------------------------------------------------------
// Registered WIDTH-bit bitwise logic unit with a single output stage and a
// valid/ready handshake on both sides. Each accepted beat computes one of
// eight operations on operand a and an effective operand b. The effective b
// is either the b port or the last accepted result, which lets a stream of
// beats fold into a running value (for example a running AND).
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   an operand beat is offered
//   in_ready   the unit can take a beat this cycle (combinational)
//   a, b       operands (b is ignored when use_prev=1)
//   op         operation select (see opCode_t)
//   use_prev   use the last accepted result in place of b
//   out_valid  out/out_zero hold a valid result
//   out_ready  the consumer takes the result this cycle
//   out        registered result
//   out_zero   registered flag, set when out == 0
// ---------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             use_prev,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_NAND = 3'b001,
    OP_OR   = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOT  = 3'b110,
    OP_ANDR = 3'b111
  } opCode_t;

  logic [WIDTH-1:0] r_out;
  logic             r_outZero;
  logic             r_outValid;
  logic [WIDTH-1:0] r_lastResult;

  logic [WIDTH-1:0] w_bEff;
  logic [WIDTH-1:0] w_result;
  logic             w_accept;

  // The output slot is free when empty or when its result leaves this cycle,
  // so a full-rate stream never sees a bubble.
  assign in_ready = !r_outValid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_bEff   = use_prev ? r_lastResult : b;

  // Operation decode. AND-reduce places &a in bit 0 and clears the rest,
  // which for WIDTH=1 degenerates to out = a.
  always_comb begin
    w_result = '0;
    case (opCode_t'(op))
      OP_AND:  w_result = a & w_bEff;
      OP_NAND: w_result = ~(a & w_bEff);
      OP_OR:   w_result = a | w_bEff;
      OP_NOR:  w_result = ~(a | w_bEff);
      OP_XOR:  w_result = a ^ w_bEff;
      OP_XNOR: w_result = ~(a ^ w_bEff);
      OP_NOT:  w_result = ~a;
      OP_ANDR: w_result[0] = &a;
      default: w_result = '0;
    endcase
  end

  // Output stage. Reset wins over any handshake and discards a held result;
  // the chaining register returns to all ones so a fresh chain starts from
  // the AND identity. An accept overwrites the slot even when the old result
  // completes at the same edge; otherwise a completion just empties it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_outZero    <= 1'b0;
      r_outValid   <= 1'b0;
      r_lastResult <= '1;
    end else if (w_accept) begin
      r_out        <= w_result;
      r_outZero    <= (w_result == '0);
      r_outValid   <= 1'b1;
      r_lastResult <= w_result;
    end else if (r_outValid && out_ready) begin
      r_outValid   <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_zero  = r_outZero;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed testbench for logic_unit_pipe: a WIDTH=16 instance for the main
// function, handshake and chaining, plus a WIDTH=1 instance for the narrow
// edge case. Inputs change 1ns after the rising edge and outputs are looked
// at in the same window, well away from the active edge.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        inValid, inReady, usePrev, outValid, outReady, outZero;
  logic [15:0] opA, opB, result;
  logic [2:0]  opSel;

  logic        inValid1, inReady1, usePrev1, outValid1, outReady1, outZero1;
  logic [0:0]  opA1, opB1, result1;
  logic [2:0]  opSel1;

  int checkCount = 0;
  int errorCount = 0;

  logic [15:0] sweepExp [8];
  logic [7:0]  narrowExp;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid), .in_ready(inReady),
    .a(opA), .b(opB), .op(opSel), .use_prev(usePrev),
    .out_valid(outValid), .out_ready(outReady),
    .out(result), .out_zero(outZero)
  );

  logic_unit_pipe #(.WIDTH(1)) dutNarrow (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid1), .in_ready(inReady1),
    .a(opA1), .b(opB1), .op(opSel1), .use_prev(usePrev1),
    .out_valid(outValid1), .out_ready(outReady1),
    .out(result1), .out_zero(outZero1)
  );

  // Single comparison point; every check is counted and mismatches reported.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one set of inputs for the wide instance.
  task automatic applyStimulus(input logic v, input logic [15:0] av,
                               input logic [15:0] bv, input logic [2:0] o,
                               input logic up, input logic rdy);
    inValid  = v;
    opA      = av;
    opB      = bv;
    opSel    = o;
    usePrev  = up;
    outReady = rdy;
  endtask

  // Advance one rising edge and settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sweepExp = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000,
                 16'hFFFF, 16'h0000, 16'h5555, 16'h0000};
    narrowExp = 8'b1001_0110;

    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b1);
    inValid1 = 1'b0; opA1 = 1'b1; opB1 = 1'b0; opSel1 = 3'd0;
    usePrev1 = 1'b0; outReady1 = 1'b1;
    step();
    step();
    checkOutput("reset out_valid", {63'd0, outValid}, 64'd0);
    checkOutput("reset out", {48'd0, result}, 64'd0);
    checkOutput("reset out_zero", {63'd0, outZero}, 64'd0);
    checkOutput("reset in_ready", {63'd0, inReady}, 64'd1);
    rst_n = 1'b1;

    // First beat: single-cycle latency.
    applyStimulus(1'b1, 16'hF0F0, 16'hFF00, 3'd0, 1'b0, 1'b1);
    step();
    checkOutput("first out_valid", {63'd0, outValid}, 64'd1);
    checkOutput("first out", {48'd0, result}, 64'h0000_0000_0000_F000);
    checkOutput("first out_zero", {63'd0, outZero}, 64'd0);

    // Operation sweep at full rate.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'hAAAA, 16'h5555, 3'(i), 1'b0, 1'b1);
      step();
      checkOutput($sformatf("sweep op%0d out", i), {48'd0, result},
                  {48'd0, sweepExp[i]});
      checkOutput($sformatf("sweep op%0d zero", i), {63'd0, outZero},
                  {63'd0, (sweepExp[i] == 16'h0)});
    end
    applyStimulus(1'b1, 16'hFFFF, 16'h0000, 3'd7, 1'b0, 1'b1);
    step();
    checkOutput("andreduce ones", {48'd0, result}, 64'h1);

    // Chaining from a fresh reset: running AND from all ones.
    applyStimulus(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'hFFF0, 16'h0000, 3'd0, 1'b1, 1'b1);
    step();
    checkOutput("chain beat0", {48'd0, result}, 64'hFFF0);
    applyStimulus(1'b1, 16'h0FFF, 16'h0000, 3'd0, 1'b1, 1'b1);
    step();
    checkOutput("chain beat1", {48'd0, result}, 64'h0FF0);
    applyStimulus(1'b1, 16'h00F0, 16'h0000, 3'd0, 1'b1, 1'b1);
    step();
    checkOutput("chain beat2", {48'd0, result}, 64'h00F0);

    // Backpressure: hold a result for three cycles, then release.
    applyStimulus(1'b1, 16'h0011, 16'h0100, 3'd2, 1'b0, 1'b1);
    step();
    checkOutput("bp held out", {48'd0, result}, 64'h0111);
    applyStimulus(1'b1, 16'h1000, 16'h0000, 3'd2, 1'b0, 1'b0);
    #1;
    checkOutput("bp in_ready low", {63'd0, inReady}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("bp stall%0d out", i), {48'd0, result}, 64'h0111);
      checkOutput($sformatf("bp stall%0d valid", i), {63'd0, outValid}, 64'd1);
      checkOutput($sformatf("bp stall%0d ready", i), {63'd0, inReady}, 64'd0);
    end
    outReady = 1'b1;
    #1;
    checkOutput("bp release ready", {63'd0, inReady}, 64'd1);
    step();
    checkOutput("bp new out", {48'd0, result}, 64'h1000);
    checkOutput("bp new valid", {63'd0, outValid}, 64'd1);
    inValid = 1'b0;
    step();
    checkOutput("bp drained valid", {63'd0, outValid}, 64'd0);
    checkOutput("bp drained out", {48'd0, result}, 64'h1000);

    // Reset during a stall discards the held result and restores chaining.
    applyStimulus(1'b1, 16'h00FF, 16'h0F0F, 3'd0, 1'b0, 1'b1);
    step();
    checkOutput("rststall pre out", {48'd0, result}, 64'h000F);
    applyStimulus(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
    step();
    checkOutput("rststall held", {63'd0, outValid}, 64'd1);
    rst_n = 1'b0;
    step();
    checkOutput("rststall valid", {63'd0, outValid}, 64'd0);
    checkOutput("rststall out", {48'd0, result}, 64'd0);
    checkOutput("rststall zero", {63'd0, outZero}, 64'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'h1234, 16'h0000, 3'd0, 1'b1, 1'b1);
    step();
    checkOutput("rststall chain", {48'd0, result}, 64'h1234);

    // WIDTH=1 instance, a=1 b=0 through every operation.
    inValid = 1'b0;
    inValid1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      opSel1 = 3'(i);
      step();
      checkOutput($sformatf("narrow op%0d out", i), {63'd0, result1},
                  {63'd0, narrowExp[i]});
      checkOutput($sformatf("narrow op%0d zero", i), {63'd0, outZero1},
                  {63'd0, ~narrowExp[i]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the single-bit two-input gates: a WIDTH-bit bitwise logic unit.
- Eight selectable operations, including a multi-way AND reduction and a chaining mode that feeds the previous result back as operand b.
- One output register stage with a valid/ready handshake.
- Sits between operand sources (register file / ALU front end) and downstream consumers in the HACK datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand a.
- b  input  WIDTH  operand b (ignored when use_prev=1).
- op  input  3  operation select (encoding below).
- use_prev  input  1  replace b with last accepted result.
- out_valid  output  1  out/out_zero hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out  output  WIDTH  registered result.
- out_zero  output  1  registered flag, 1 when out == 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - out_valid=0, out=0, out_zero=0.
  - Internal last_result = all ones (AND identity).
  - Reset takes priority over any concurrent handshake; a held result is discarded.
- Operand b_eff = use_prev ? last_result : b.
- op encoding:
  - 000 AND: a&b_eff
  - 001 NAND: ~(a&b_eff)
  - 010 OR: a|b_eff
  - 011 NOR: ~(a|b_eff)
  - 100 XOR: a^b_eff
  - 101 XNOR: ~(a^b_eff)
  - 110 NOT: ~a; b_eff ignored
  - 111 AND-reduce: bit0 = &a, bits WIDTH-1..1 = 0; b_eff ignored
- Input accept: a beat is accepted at an edge where in_valid && in_ready.
- in_ready = !out_valid || out_ready (combinational; no registered bubble).
- On accept:
  - out <= result; out_zero <= (result==0); out_valid <= 1.
  - last_result <= result.
- Latency is exactly 1 cycle: a result accepted at edge N is visible after edge N.
- Throughput is 1 beat/cycle while out_ready=1.
- Output complete (out_valid && out_ready) with no accept at the same edge: out_valid <= 0; out, out_zero and last_result hold.
- Simultaneous complete and accept: the new result replaces the old one; out_valid stays 1; no beat is lost or duplicated.
- Stall (out_valid=1, out_ready=0):
  - in_ready=0; out and out_zero stable.
  - a, b, op and use_prev are ignored.
- Chaining: last_result updates only on accept, so back-to-back use_prev beats fold correctly at full rate. Example: AND across a stream gives a running AND starting from all ones.
- in_valid=0: no state change except an output completion.
- No combinational path from a/b/op to out; the only combinational path is out_ready -> in_ready.
- WIDTH=1 edge: AND-reduce yields out = a.

Test Plan:
- Reset, then in_valid=1, a=16'hF0F0, b=16'hFF00, op=000, out_ready=1 -> next cycle out_valid=1, out=16'hF000, out_zero=0.
- op sweep with a=16'hAAAA, b=16'h5555 -> AND 0000 (out_zero=1); NAND FFFF; OR FFFF; NOR 0000; XOR FFFF; XNOR 0000; NOT 5555; AND-reduce 0000. Then a=FFFF, op=111 -> 0001.
- Chain after reset: use_prev=1, op=000, beats a=FFF0, 0FFF, 00F0 back-to-back -> outputs FFF0, 0FF0, 00F0 on consecutive cycles.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out frozen; release -> the held result completes and the new beat is accepted at the same edge, with no loss or duplicate.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 for 1 edge -> out_valid=0, out=0. Next use_prev beat a=1234, op=000 -> out=1234, proving last_result was restored to all ones.
- WIDTH=1 instance: a=1, b=0 exercised across all ops -> 0,1,1,0,1,0,0,1.
